// File: rtl/mc_core_pkg.sv
// Shared definitions for the multicycle core: opcodes, FSM states, ALU operations and field widths.
package mc_core_pkg;

  localparam int OP_W    = 4;
  localparam int REG_W   = 4;
  localparam int IMM8_W  = 8;
  localparam int IMM12_W = 12;
  localparam int NREGS   = 16;

  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_AND  = 4'h2;
  localparam logic [OP_W-1:0] OP_OR   = 4'h3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'h5;
  localparam logic [OP_W-1:0] OP_LI   = 4'h6;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h7;
  localparam logic [OP_W-1:0] OP_LW   = 4'h8;
  localparam logic [OP_W-1:0] OP_SW   = 4'h9;
  localparam logic [OP_W-1:0] OP_BNZ  = 4'hA;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT
  } alu_op_e;

  // ADDI shares the adder; non-ALU opcodes fall back to ADD and their result is unused.
  function automatic alu_op_e alu_op_of(input logic [OP_W-1:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      OP_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU of the core: wrap-around add/sub with carry (borrow on SUB), logic ops, signed SLT.
module mc_alu
  import mc_core_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  alu_op_e                  op_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] result_o,
  output logic                     carry_o
);

  logic [DATA_W:0] sum;

  always_comb begin
    sum      = '0;
    result_o = '0;
    carry_o  = 1'b0;
    unique case (op_i)
      ALU_ADD: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      // Bit DATA_W of the zero-extended difference is set exactly when a < b unsigned.
      ALU_SUB: begin
        sum      = {1'b0, a_i} - {1'b0, b_i};
        result_o = sum[DATA_W-1:0];
        carry_o  = sum[DATA_W];
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_core_seq.sv
// Multicycle 16-bit-ISA core: FETCH/DECODE/EXEC/MEM/WB control FSM, inline register file and
// datapath registers, single-port memory with a req/ready handshake of arbitrary latency.
module mc_core_seq
  import mc_core_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic              carry,
  output logic [ADDR_W-1:0] pc_out
);

  state_e                   state_q;
  logic [ADDR_W-1:0]        pc_q;
  logic [15:0]              ir_q;
  logic signed [DATA_W-1:0] a_q, b_q, aluout_q, mdr_q;
  logic                     carry_q, req_q;
  logic [DATA_W-1:0]        rf_q [NREGS];

  logic [OP_W-1:0]          op_d;
  logic [REG_W-1:0]         rd_d, rs_d, rt_d;
  logic [IMM8_W-1:0]        imm8_d;
  logic [IMM12_W-1:0]       imm12_d;
  logic [DATA_W-1:0]        rd_val_d, rs_val_d, rt_val_d;
  logic signed [DATA_W-1:0] imm_data_d, alu_b_d, alu_res_d;
  logic [ADDR_W-1:0]        br_off_d;
  logic                     alu_carry_d;

  assign op_d    = ir_q[15:12];
  assign rd_d    = ir_q[11:8];
  assign rs_d    = ir_q[7:4];
  assign rt_d    = ir_q[3:0];
  assign imm8_d  = ir_q[7:0];
  assign imm12_d = ir_q[11:0];

  assign rd_val_d   = (rd_d == '0) ? '0 : rf_q[rd_d];
  assign rs_val_d   = (rs_d == '0) ? '0 : rf_q[rs_d];
  assign rt_val_d   = (rt_d == '0) ? '0 : rf_q[rt_d];
  assign imm_data_d = DATA_W'($signed(imm8_d));
  assign br_off_d   = (op_d == OP_JMP) ? ADDR_W'($signed(imm12_d)) : ADDR_W'($signed(imm8_d));
  assign alu_b_d    = (op_d == OP_ADDI) ? imm_data_d : b_q;

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (alu_op_of(op_d)),
    .a_i      (a_q),
    .b_i      (alu_b_d),
    .result_o (alu_res_d),
    .carry_o  (alu_carry_d)
  );

  // Address, direction and store data come from registers that hold still for a whole access.
  assign mem_req   = req_q;
  assign mem_we    = (state_q == ST_MEM) && (op_d == OP_SW);
  assign mem_addr  = (state_q == ST_MEM) ? a_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata = b_q;
  assign halted    = (state_q == ST_HALT);
  assign carry     = carry_q;
  assign pc_out    = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= RST_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      carry_q  <= 1'b0;
      req_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      unique case (state_q)
        // Only the first fetch after reset arrives with req low; every other entry raises it.
        ST_FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (mem_ready) begin
            ir_q    <= mem_rdata[15:0];
            pc_q    <= pc_q + 1'b1;
            req_q   <= 1'b0;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_q     <= (op_d == OP_ADDI || op_d == OP_BNZ) ? rd_val_d : rs_val_d;
          b_q     <= rt_val_d;
          state_q <= (op_d == OP_HALT) ? ST_HALT : ST_EXEC;
        end
        ST_EXEC: begin
          case (op_d)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI: begin
              aluout_q <= alu_res_d;
              if (op_d == OP_ADD || op_d == OP_SUB || op_d == OP_ADDI) carry_q <= alu_carry_d;
              state_q  <= ST_WB;
            end
            OP_LI: begin
              aluout_q <= imm_data_d;
              state_q  <= ST_WB;
            end
            OP_LW, OP_SW: begin
              req_q   <= 1'b1;
              state_q <= ST_MEM;
            end
            OP_BNZ, OP_JMP: begin
              if (op_d == OP_JMP || a_q != '0) pc_q <= pc_q + br_off_d;
              req_q   <= 1'b1;
              state_q <= ST_FETCH;
            end
            default: begin
              req_q   <= 1'b1;
              state_q <= ST_FETCH;
            end
          endcase
        end
        // A completed store chains straight into the next fetch, so req stays high.
        ST_MEM: begin
          if (mem_ready) begin
            if (op_d == OP_LW) begin
              mdr_q   <= mem_rdata;
              req_q   <= 1'b0;
              state_q <= ST_WB;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        ST_WB: begin
          if (rd_d != '0) rf_q[rd_d] <= (op_d == OP_LW) ? mdr_q : aluout_q;
          req_q   <= 1'b1;
          state_q <= ST_FETCH;
        end
        ST_HALT: ;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_seq.sv
// Bench for mc_core_seq: wait-state memory model, store scoreboard, cycle-count and handshake checks.
module tb_mc_core_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rst32 = 1'b1;
  logic        mem_req, mem_we, mem_ready = 1'b0, halted, carry;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0, pc_out;
  logic        m32_req, m32_we, m32_ready = 1'b0, halted32, carry32;
  logic [15:0] m32_addr, pc32;
  logic [31:0] m32_wdata, m32_rdata = '0;

  mc_core_seq #(.DATA_W(16), .ADDR_W(16), .RST_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .halted(halted), .carry(carry), .pc_out(pc_out)
  );

  mc_core_seq #(.DATA_W(32), .ADDR_W(16), .RST_PC(16'h0000)) dut32 (
    .clk(clk), .rst(rst32), .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr),
    .mem_wdata(m32_wdata), .mem_ready(m32_ready), .mem_rdata(m32_rdata),
    .halted(halted32), .carry(carry32), .pc_out(pc32)
  );

  typedef struct packed {logic [15:0] a; logic [31:0] d;} st_t;
  st_t exp_q[$], exp32_q[$];

  int    checks = 0, failures = 0;
  string tname = "init";

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got %0h expected %0h", tname, tag, act, exp);
    end
  endtask

  task automatic sb_store(input logic [15:0] a, input logic [31:0] d, inout st_t q[$]);
    st_t e;
    check_val("sb_pending", (q.size() != 0), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check_val("st_addr", a, e.a);
      check_val("st_data", d, e.d);
    end
  endtask

  logic [15:0] mem16 [65536];
  logic [31:0] mem32 [65536];
  int          wait_n = 0, wcnt = 0, run_len = 0, viol = 0, cnt1 = 0, cntF = 0;
  bit          saw_pc0 = 0;
  logic [15:0] acc_addr, acc_wdata;
  logic        acc_we;
  logic [15:0] prog_q[$];

  // 16-bit memory: ready after wait_n wait cycles; also audits that each access holds still.
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      wcnt = 0; run_len = 0; mem_ready = 1'b0;
    end else begin
      if (run_len == 0) begin
        acc_addr = mem_addr; acc_we = mem_we; acc_wdata = mem_wdata;
      end else if (mem_addr !== acc_addr || mem_we !== acc_we ||
                   (acc_we && mem_wdata !== acc_wdata)) begin
        viol++;
      end
      run_len++;
      mem_ready = (wcnt == wait_n);
      mem_rdata = mem16[mem_addr];
      if (mem_ready) begin
        if (run_len != wait_n + 1) viol++;
        run_len = 0; wcnt = 0;
        if (mem_we) begin
          mem16[mem_addr] = mem_wdata;
          sb_store(mem_addr, {16'h0, mem_wdata}, exp_q);
        end else begin
          if (mem_addr == 16'h0001) cnt1++;
          if (mem_addr == 16'hFFFF) cntF++;
        end
      end else begin
        wcnt++;
      end
    end
    if (!rst && cntF > 0 && pc_out == 16'h0000) saw_pc0 = 1;
  end

  always @(negedge clk) begin
    if (rst32 || !m32_req) begin
      m32_ready = 1'b0;
    end else begin
      m32_ready = 1'b1;
      m32_rdata = mem32[m32_addr];
      if (m32_we) begin
        mem32[m32_addr] = m32_wdata;
        sb_store(m32_addr, m32_wdata, exp32_q);
      end
    end
  end

  task automatic begin_reset(input int wn);
    @(posedge clk); #2;
    rst = 1'b1; wait_n = wn; viol = 0; cnt1 = 0; cntF = 0; saw_pc0 = 0;
    exp_q.delete();
    for (int i = 0; i < 65536; i++) mem16[i] = 16'h0000;
    foreach (prog_q[i]) mem16[i] = prog_q[i];
  endtask

  task automatic end_reset();
    @(posedge clk); #2;
    @(negedge clk);
    check_val("rst_req", mem_req, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_pc", pc_out, 16'h0000);
    check_val("rst_carry", carry, 0);
    @(posedge clk); #2 rst = 1'b0;
  endtask

  task automatic run_until(input int budget, input bit loop_mode, output int t_len);
    int t = 0, tf = -1;
    bit done = 0;
    t_len = -1;
    while (!done && t < budget) begin
      @(negedge clk);
      t++;
      if (tf < 0 && mem_req) tf = t;
      done = halted || (loop_mode && cntF >= 4);
    end
    check_val("run_done", done, 1);
    if (done) t_len = t - tf + 1;
  endtask

  task automatic push16(input logic [15:0] a, input logic [15:0] d);
    exp_q.push_back('{a: a, d: {16'h0, d}});
  endtask

  initial begin
    int tl, n;

    for (int i = 0; i < 65536; i++) mem32[i] = 32'h0;
    mem32[0] = 32'h61FF; mem32[1] = 32'h6201; mem32[2] = 32'h0312; mem32[3] = 32'h6F40;
    mem32[4] = 32'h90F3; mem32[5] = 32'h6E41; mem32[6] = 32'h90E1; mem32[7] = 32'hF000;
    exp32_q.push_back('{a: 16'h0040, d: 32'h0000_0000});
    exp32_q.push_back('{a: 16'h0041, d: 32'hFFFF_FFFF});
    repeat (2) @(posedge clk);
    #2 rst32 = 1'b0;

    tname = "t1_add";
    prog_q = '{16'h6105, 16'h62FD, 16'h0312, 16'h6F40, 16'h90F3, 16'hF000};
    begin_reset(0);
    push16(16'h0040, 16'h0002);
    end_reset();
    run_until(200, 0, tl);
    check_val("cycles", tl, 23);
    check_val("carry", carry, 1);
    check_val("pc", pc_out, 16'h0006);
    check_val("sb_drained", exp_q.size(), 0);

    tname = "t2_alu";
    prog_q = '{16'h6101, 16'h6202, 16'h1312, 16'h5412, 16'h4532, 16'h3612, 16'h2731, 16'h5821,
               16'h5931, 16'h6F40, 16'h90F3, 16'h6F41, 16'h90F4, 16'h6F42, 16'h90F5, 16'h6F43,
               16'h90F6, 16'h6F44, 16'h90F7, 16'h6F45, 16'h90F8, 16'h6F46, 16'h90F9, 16'hF000};
    begin_reset(0);
    push16(16'h0040, 16'hFFFF); push16(16'h0041, 16'h0001); push16(16'h0042, 16'hFFFD);
    push16(16'h0043, 16'h0003); push16(16'h0044, 16'h0001); push16(16'h0045, 16'h0000);
    push16(16'h0046, 16'h0001);
    end_reset();
    run_until(400, 0, tl);
    check_val("carry", carry, 1);
    check_val("pc", pc_out, 16'h0018);
    check_val("sb_drained", exp_q.size(), 0);

    tname = "w32";
    check_val("halted", halted32, 1);
    check_val("carry", carry32, 1);
    check_val("pc", pc32, 16'h0008);
    check_val("sb_drained", exp32_q.size(), 0);

    tname = "t3_wait";
    prog_q = '{16'h6140, 16'h62A5, 16'h9012, 16'h8510, 16'h6150, 16'h9015, 16'hF000};
    begin_reset(3);
    push16(16'h0040, 16'hFFA5); push16(16'h0050, 16'hFFA5);
    end_reset();
    run_until(400, 0, tl);
    check_val("cycles", tl, 58);
    check_val("hold_stable", viol, 0);
    check_val("sb_drained", exp_q.size(), 0);

    tname = "t4_loop";
    prog_q = '{16'h6103, 16'h71FF, 16'hA1FE, 16'h6F40, 16'h90F1, 16'hF000};
    begin_reset(0);
    push16(16'h0040, 16'h0000);
    end_reset();
    run_until(400, 0, tl);
    check_val("cycles", tl, 36);
    check_val("addi_fetches", cnt1, 3);
    check_val("pc", pc_out, 16'h0006);
    check_val("carry", carry, 1);
    check_val("sb_drained", exp_q.size(), 0);

    tname = "t5_r0_wrap";
    prog_q = '{16'h6007, 16'h0100, 16'h6F40, 16'h90F1, 16'h62FF, 16'h7201, 16'h6E41,
               16'h90E2, 16'h7E01, 16'h90E0, 16'hBFF4};
    begin_reset(1);
    mem16[16'hFFFF] = 16'hBFFF;
    push16(16'h0040, 16'h0000); push16(16'h0041, 16'h0000); push16(16'h0042, 16'h0000);
    end_reset();
    run_until(600, 1, tl);
    check_val("pc_wrapped_to_0", saw_pc0, 1);
    check_val("halted", halted, 0);
    check_val("carry", carry, 0);
    check_val("hold_stable", viol, 0);
    check_val("sb_drained", exp_q.size(), 0);

    tname = "t6_rst_mem";
    prog_q = '{16'h6140, 16'h6211, 16'h9012, 16'hF000};
    begin_reset(3);
    mem16[16'h0040] = 16'hDEAD;
    end_reset();
    n = 0;
    for (int t = 0; t < 200 && n < 2; t++) begin
      @(negedge clk);
      if (mem_req && mem_we) n++;
    end
    check_val("reached_mem", n, 2);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val("req_dropped", mem_req, 0);
    check_val("pc_reset", pc_out, 16'h0000);
    check_val("target_kept", mem16[16'h0040], 16'hDEAD);
    check_val("no_write", exp_q.size(), 0);
    check_val("hold_stable", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
